range_session_ctrl: RTL and testbench

RANGE_SESSION_CTRL -- requirements
Module: range_session_ctrl

---
 rtl/range_session_ctrl.sv | 152 +++++++++++++++
 tb/tb_range_session_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/range_session_ctrl.sv
// Session sequencer for an attached min/max range unit: accepts a sample count,
// streams that many samples through, and returns the captured range and count.
module range_session_ctrl #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_ready,
    input  logic             smp_valid,
    input  logic [WIDTH-1:0] smp_data,
    output logic             smp_ready,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_range,
    output logic [CNT_W-1:0] res_count,
    output logic             res_error,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_error_q, res_error_d;
    logic [WIDTH-1:0] res_range_q, res_range_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             smp_hs;
    logic [CNT_W-1:0] count_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            res_count_q <= '0;
            res_error_q <= 1'b0;
            res_range_q <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            res_count_q <= res_count_d;
            res_error_q <= res_error_d;
            res_range_q <= res_range_d;
            last_q      <= last_d;
        end
    end

    // Count saturates rather than wrapping.
    assign count_inc = (res_count_q == {CNT_W{1'b1}}) ? res_count_q
                                                      : res_count_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        res_count_d = res_count_q;
        res_error_d = res_error_q;
        res_range_d = res_range_q;
        last_d      = last_q;
        cmd_ready   = 1'b0;
        smp_ready   = 1'b0;
        smp_hs      = 1'b0;
        rf_go       = 1'b0;
        rf_finish   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    remaining_d = cmd_count;
                    res_count_d = '0;
                    res_error_d = 1'b0;
                    res_range_d = '0;
                    if (cmd_count < CNT_W'(2)) begin
                        res_error_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_FIRST;
                    end
                end
            end
            S_FIRST: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    smp_ready = 1'b1;
                    if (smp_valid) begin
                        smp_hs      = 1'b1;
                        rf_go       = 1'b1;
                        last_d      = smp_data;
                        res_count_d = count_inc;
                        remaining_d = remaining_q - CNT_W'(1);
                        state_d     = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Close the range unit's session; the pending sample is refused.
                    rf_finish = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    smp_ready = 1'b1;
                    if (smp_valid) begin
                        smp_hs      = 1'b1;
                        last_d      = smp_data;
                        res_count_d = count_inc;
                        if (remaining_q == CNT_W'(1)) begin
                            rf_finish   = 1'b1;
                            res_range_d = rf_range;
                            res_error_d = res_error_q | rf_error;
                            state_d     = S_DONE;
                        end else begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outside a handshake the range unit sees the last sample, leaving min/max untouched.
    assign rf_data   = smp_hs ? smp_data : last_q;
    assign res_valid = (state_q == S_DONE);
    assign res_range = res_range_q;
    assign res_count = res_count_q;
    assign res_error = res_error_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_range_session_ctrl.sv
// Randomized self-checking bench for range_session_ctrl with a behavioural
// min/max range unit and a per-session max-minus-min reference.
module tb_range_session_ctrl;
    localparam int W = 10;
    localparam int C = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic [C-1:0] cmd_count;
    logic         cmd_ready;
    logic         smp_valid;
    logic [W-1:0] smp_data;
    logic         smp_ready;
    logic         abort;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_range;
    logic [C-1:0] res_count;
    logic         res_error;
    logic [W-1:0] rf_data;
    logic         rf_go;
    logic         rf_finish;
    logic [W-1:0] rf_range;
    logic         rf_error;
    logic         busy;

    range_session_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_count(cmd_count), .cmd_ready(cmd_ready),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
        .abort(abort),
        .res_valid(res_valid), .res_ready(res_ready), .res_range(res_range),
        .res_count(res_count), .res_error(res_error),
        .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish),
        .rf_range(rf_range), .rf_error(rf_error), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural range unit: running min/max since rf_go, combinational result.
    logic [W-1:0] rmin_q, rmax_q, lo, hi;
    always @(posedge clock) begin
        if (rf_go) begin
            rmin_q <= rf_data;
            rmax_q <= rf_data;
        end else begin
            if (rf_data < rmin_q) rmin_q <= rf_data;
            if (rf_data > rmax_q) rmax_q <= rf_data;
        end
    end
    always_comb begin
        lo = rf_go ? rf_data : ((rf_data < rmin_q) ? rf_data : rmin_q);
        hi = rf_go ? rf_data : ((rf_data > rmax_q) ? rf_data : rmax_q);
        rf_range = hi - lo;
    end

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] last_acc = '0;
    logic [W-1:0] smp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One session: n samples, gap<0 means random gaps; abort_at/rst_at < 0 disable.
    task automatic run_session(input int n, input int gap, input int abort_at,
                               input int rst_at, input bit err, input int hold);
        logic [W-1:0] s[$];
        logic [W-1:0] mn, mx, exp_range;
        logic [C-1:0] exp_cnt;
        bit           exp_err;
        int           g;
        int           waited;
        rf_error  = err;
        cmd_valid = 1'b1;
        cmd_count = C'(n);
        #2;
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        if (n >= 2) begin
            s = smp_q;
            smp_q.delete();
            while (s.size() < n) s.push_back(W'($urandom_range(0, 1023)));
            for (int i = 0; i < n; i++) begin
                g = (gap < 0) ? $urandom_range(0, 2) : gap;
                for (int k = 0; k < g; k++) begin
                    smp_valid = 1'b0;
                    smp_data  = W'($urandom);
                    #2;
                    check("gap_rf_data", rf_data, last_acc);
                    check("gap_pulses", {rf_go, rf_finish}, 0);
                    check("gap_busy", busy, 1);
                    tick();
                end
                if (i == rst_at) begin
                    smp_valid = 1'b0;
                    reset = 1'b1;
                    #1;
                    check("rst_busy", busy, 0);
                    check("rst_pulses", {rf_go, rf_finish}, 0);
                    check("rst_cmd_ready", cmd_ready, 1);
                    check("rst_res_valid", res_valid, 0);
                    check("rst_rf_data", rf_data, 0);
                    tick();
                    reset = 1'b0;
                    last_acc = '0;
                    tick();
                    return;
                end
                if (i == abort_at) begin
                    abort     = 1'b1;
                    smp_valid = 1'b1;
                    smp_data  = s[i];
                    #2;
                    check("abort_smp_ready", smp_ready, 0);
                    check("abort_rf_go", rf_go, 0);
                    check("abort_rf_finish", rf_finish, (i > 0) ? 1 : 0);
                    check("abort_rf_data", rf_data, last_acc);
                    tick();
                    abort     = 1'b0;
                    smp_valid = 1'b0;
                    #2;
                    check("abort_cmd_ready", cmd_ready, 1);
                    check("abort_res_valid", res_valid, 0);
                    check("abort_pulses", {rf_go, rf_finish}, 0);
                    return;
                end
                smp_valid = 1'b1;
                smp_data  = s[i];
                #2;
                check("smp_ready", smp_ready, 1);
                check("smp_rf_data", rf_data, s[i]);
                check("smp_rf_go", rf_go, (i == 0) ? 1 : 0);
                check("smp_rf_finish", rf_finish, (i == n - 1) ? 1 : 0);
                last_acc = s[i];
                tick();
            end
            smp_valid = 1'b0;
            mn = s[0];
            mx = s[0];
            for (int i = 1; i < n; i++) begin
                if (s[i] < mn) mn = s[i];
                if (s[i] > mx) mx = s[i];
            end
            exp_range = mx - mn;
            exp_cnt   = C'(n);
            exp_err   = err;
        end else begin
            #2;
            check("short_pulses", {rf_go, rf_finish}, 0);
            exp_range = '0;
            exp_cnt   = '0;
            exp_err   = 1'b1;
        end
        waited = 0;
        while (!res_valid && waited < 20) begin
            tick();
            waited++;
        end
        check("res_valid", res_valid, 1);
        for (int h = 0; h <= hold; h++) begin
            res_ready = (h == hold);
            smp_valid = 1'($urandom);
            smp_data  = W'($urandom);
            abort     = 1'($urandom);
            #2;
            check("done_range", res_range, exp_range);
            check("done_count", res_count, exp_cnt);
            check("done_error", res_error, exp_err);
            check("done_cmd_ready", cmd_ready, 0);
            check("done_smp_ready", smp_ready, 0);
            check("done_rf_data", rf_data, last_acc);
            check("done_pulses", {rf_go, rf_finish}, 0);
            tick();
        end
        res_ready = 1'b0;
        smp_valid = 1'b0;
        abort     = 1'b0;
        #2;
        check("post_busy", busy, 0);
        check("post_cmd_ready", cmd_ready, 1);
        check("post_res_valid", res_valid, 0);
    endtask

    initial begin
        int n, ab;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_count = '0;
        smp_valid = 1'b0;
        smp_data  = '0;
        abort     = 1'b0;
        res_ready = 1'b0;
        rf_error  = 1'b0;
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rf_data", rf_data, 0);
        check("rst_pulses", {rf_go, rf_finish}, 0);
        check("rst_res", {res_range, res_count, res_error}, 0);
        tick();
        reset = 1'b0;
        tick();

        smp_q = '{10'd5, 10'd9, 10'd2, 10'd7};
        run_session(4, 0, -1, -1, 1'b0, 0);
        smp_q = '{10'd10, 10'd3, 10'd6};
        run_session(3, 2, -1, -1, 1'b0, 0);
        run_session(1, 0, -1, -1, 1'b0, 0);
        run_session(0, 0, -1, -1, 1'b0, 0);
        run_session(5, 0, 2, -1, 1'b0, 0);
        run_session(4, 1, 0, -1, 1'b0, 0);
        run_session(3, 0, 2, -1, 1'b0, 0);
        run_session(3, 0, -1, -1, 1'b1, 10);
        run_session(6, 0, -1, 3, 1'b0, 0);
        smp_q = '{10'd1000, 10'd24};
        run_session(2, 0, -1, -1, 1'b0, 1);
        run_session(255, 0, -1, -1, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            n  = $urandom_range(0, 9);
            ab = ((n >= 2) && ($urandom_range(0, 3) == 0)) ? $urandom_range(0, n - 1) : -1;
            run_session(n, -1, ab, -1, 1'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
